// File: rtl/inst_fetch_unit.sv
// MIPS IF stage: owns the fetch PC, drives a req/ack instruction-memory port and
// buffers fetched words in a small in-order queue whose head is presented to ID.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_rst,
  input  logic        if_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        valid_id,
  output logic [31:0] inst_id,
  output logic [31:0] pc_id,
  output logic [31:0] pc4_id,
  output logic        fetch_busy
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QD_C = CW'(QDEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem   [QDEPTH];
  logic [31:0]   inst_mem [QDEPTH];

  logic          rst_s;
  logic          ack_s;
  logic          valid_s;
  logic          deq_s;
  logic          enq_s;
  logic          issue_s;
  logic [CW-1:0] count_nxt_s;
  logic [31:0]   target_s;
  logic [31:0]   pc_plus4_s;
  logic          unused_s;

  assign rst_s       = rst | if_rst;
  // An ack is only meaningful while a request is actually on the port.
  assign ack_s       = req_q & imem_ack;
  assign valid_s     = (count_q != '0) & ~redirect;
  assign deq_s       = valid_s & if_en;
  assign enq_s       = (state_q == S_REQ) & ack_s & ~redirect;
  assign count_nxt_s = count_q + CW'(enq_s) - CW'(deq_s);
  assign issue_s     = (count_nxt_s < QD_C);
  assign target_s    = {redirect_pc[31:2], 2'b00};
  assign pc_plus4_s  = fetch_pc_q + 32'd4;
  assign unused_s    = ^redirect_pc[1:0];

  // Fetch FSM next-state and request-port control.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    if (redirect) begin
      fetch_pc_d = target_s;
      // An unanswered request must still complete on its old address.
      if ((state_q != S_IDLE) && !ack_s) begin
        state_d = S_DROP;
      end else begin
        state_d = S_REQ;
        req_d   = 1'b1;
        addr_d  = target_s;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue_s) begin
            state_d = S_REQ;
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
          end else begin
            req_d   = 1'b0;
          end
        end
        S_REQ: begin
          if (ack_s) begin
            fetch_pc_d = pc_plus4_s;
            if (issue_s) begin
              req_d  = 1'b1;
              addr_d = pc_plus4_s;
            end else begin
              state_d = S_IDLE;
              req_d   = 1'b0;
            end
          end else begin
            req_d = 1'b1;
          end
        end
        S_DROP: begin
          if (ack_s) begin
            state_d = S_REQ;
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
          end else begin
            req_d   = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  // Queue occupancy and pointer update; a redirect flushes everything.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_nxt_s;
      rd_ptr_d = rd_ptr_q + PW'(deq_s);
      wr_ptr_d = wr_ptr_q + PW'(enq_s);
    end
  end

  // State registers with synchronous stage reset.
  always_ff @(posedge clk) begin
    if (rst_s) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= 32'd0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage; entries are only observed while counted, so no reset needed.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      pc_mem[wr_ptr_q]   <= addr_q;
      inst_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign valid_id   = valid_s;
  assign fetch_busy = (count_q == '0);
  assign inst_id    = (count_q != '0) ? inst_mem[rd_ptr_q] : 32'd0;
  assign pc_id      = (count_q != '0) ? pc_mem[rd_ptr_q] : 32'd0;
  assign pc4_id     = (count_q != '0) ? (pc_mem[rd_ptr_q] + 32'd4) : 32'd0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: zero-wait, backpressure, wait states,
// redirects (pending and same-cycle ack) and reset during a dropped request.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        if_rst;
  logic        if_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        valid_id;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic [31:0] pc4_id;
  logic        fetch_busy;

  logic        ack_all;
  logic        ack_man;
  logic        bad_data;
  int          checks;
  int          errors;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_rst     (if_rst),
    .if_en      (if_en),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .valid_id   (valid_id),
    .inst_id    (inst_id),
    .pc_id      (pc_id),
    .pc4_id     (pc4_id),
    .fetch_busy (fetch_busy)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imem_ack   = ack_all | ack_man;
  assign imem_rdata = bad_data ? 32'hDEAD_BEEF : word_at(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   32'(imem_req),   32'd0);
    check_eq({tag, "_valid"}, 32'(valid_id),   32'd0);
    check_eq({tag, "_inst"},  inst_id,         32'd0);
    check_eq({tag, "_pc"},    pc_id,           32'd0);
    check_eq({tag, "_pc4"},   pc4_id,          32'd0);
    check_eq({tag, "_busy"},  32'(fetch_busy), 32'd1);
  endtask

  task automatic do_reset(input bit via_if, input string tag);
    if (via_if) begin
      if_rst = 1'b1;
    end else begin
      rst = 1'b1;
    end
    redirect = 1'b0;
    tick;
    check_reset_outputs(tag);
    rst    = 1'b0;
    if_rst = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    if_rst      = 1'b0;
    if_en       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    ack_all     = 1'b0;
    ack_man     = 1'b0;
    bad_data    = 1'b0;

    // Zero-wait streaming: one instruction per cycle.
    ack_all = 1'b1;
    if_en   = 1'b1;
    do_reset(1'b0, "zw_rst");
    tick;
    check_eq("zw_req0",   32'(imem_req), 32'd1);
    check_eq("zw_addr0",  imem_addr,     32'h0);
    check_eq("zw_valid0", 32'(valid_id), 32'd0);
    tick;
    check_eq("zw_valid1", 32'(valid_id), 32'd1);
    check_eq("zw_pc1",    pc_id,         32'h0);
    check_eq("zw_pc4_1",  pc4_id,        32'h4);
    check_eq("zw_inst1",  inst_id,       32'hC0DE_0000);
    check_eq("zw_addr1",  imem_addr,     32'h4);
    for (int i = 1; i <= 4; i++) begin
      tick;
      check_eq("zw_valid", 32'(valid_id), 32'd1);
      check_eq("zw_pc",    pc_id,         32'(4 * i));
      check_eq("zw_inst",  inst_id,       word_at(32'(4 * i)));
      check_eq("zw_addr",  imem_addr,     32'(4 * (i + 1)));
    end

    // Backpressure: exactly two words buffered, then request drops.
    if_en = 1'b0;
    do_reset(1'b0, "bp_rst");
    tick;
    check_eq("bp_addr0", imem_addr,     32'h0);
    tick;
    check_eq("bp_valid", 32'(valid_id), 32'd1);
    check_eq("bp_addr1", imem_addr,     32'h4);
    tick;
    check_eq("bp_req_off", 32'(imem_req), 32'd0);
    check_eq("bp_head0",   pc_id,         32'h0);
    tick;
    check_eq("bp_req_off2", 32'(imem_req),   32'd0);
    check_eq("bp_head_hold", pc_id,          32'h0);
    check_eq("bp_busy",     32'(fetch_busy), 32'd0);
    if_en = 1'b1;
    tick;
    check_eq("bp_head4", pc_id,         32'h4);
    check_eq("bp_req_on", 32'(imem_req), 32'd1);
    check_eq("bp_addr8", imem_addr,     32'h8);
    tick;
    check_eq("bp_head8",  pc_id,         32'h8);
    check_eq("bp_valid8", 32'(valid_id), 32'd1);
    tick;
    check_eq("bp_head12", pc_id, 32'hC);

    // Wait states: ack three cycles late, via the controller stage reset.
    ack_all = 1'b0;
    ack_man = 1'b0;
    if_en   = 1'b1;
    do_reset(1'b1, "ws_rst");
    tick;
    check_eq("ws_req0", 32'(imem_req), 32'd1);
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 3; w++) begin
        tick;
        check_eq("ws_req_hold",  32'(imem_req),   32'd1);
        check_eq("ws_addr_hold", imem_addr,       32'(4 * k));
        check_eq("ws_bubble",    32'(valid_id),   32'd0);
        check_eq("ws_busy",      32'(fetch_busy), 32'd1);
      end
      ack_man = 1'b1;
      tick;
      ack_man = 1'b0;
      check_eq("ws_valid", 32'(valid_id), 32'd1);
      check_eq("ws_pc",    pc_id,         32'(4 * k));
      check_eq("ws_inst",  inst_id,       word_at(32'(4 * k)));
    end

    // Redirect while a request is pending: the late response is discarded.
    ack_man = 1'b0;
    if_en   = 1'b1;
    do_reset(1'b0, "rp_rst");
    tick;
    ack_man = 1'b1;
    repeat (4) tick;
    check_eq("rp_addr10", imem_addr, 32'h10);
    ack_man     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    check_eq("rp_valid_redir", 32'(valid_id), 32'd0);
    tick;
    redirect = 1'b0;
    check_eq("rp_req_old",  32'(imem_req),   32'd1);
    check_eq("rp_addr_old", imem_addr,       32'h10);
    check_eq("rp_flushed",  32'(fetch_busy), 32'd1);
    tick;
    check_eq("rp_addr_old2", imem_addr, 32'h10);
    bad_data = 1'b1;
    ack_man  = 1'b1;
    tick;
    bad_data = 1'b0;
    check_eq("rp_addr_new", imem_addr,     32'h100);
    check_eq("rp_no_bad",   inst_id,       32'd0);
    check_eq("rp_valid0",   32'(valid_id), 32'd0);
    tick;
    check_eq("rp_valid_new", 32'(valid_id), 32'd1);
    check_eq("rp_pc_new",    pc_id,         32'h100);
    check_eq("rp_pc4_new",   pc4_id,        32'h104);
    check_eq("rp_inst_new",  inst_id,       32'hC0DE_0100);

    // Redirect with same-cycle ack while the queue holds an entry.
    ack_man = 1'b0;
    if_en   = 1'b0;
    do_reset(1'b0, "ra_rst");
    tick;
    redirect    = 1'b1;
    redirect_pc = 32'h20;
    ack_man     = 1'b1;
    tick;
    redirect = 1'b0;
    check_eq("ra_addr20", imem_addr,     32'h20);
    check_eq("ra_valid0", 32'(valid_id), 32'd0);
    tick;
    tick;
    check_eq("ra_req_off", 32'(imem_req), 32'd0);
    check_eq("ra_head20",  pc_id,         32'h20);
    if_en   = 1'b1;
    ack_man = 1'b0;
    tick;
    check_eq("ra_head24", pc_id,     32'h24);
    check_eq("ra_addr28", imem_addr, 32'h28);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    ack_man     = 1'b1;
    #1;
    check_eq("ra_valid_redir", 32'(valid_id), 32'd0);
    tick;
    redirect = 1'b0;
    check_eq("ra_flushed", 32'(fetch_busy), 32'd1);
    check_eq("ra_addr40",  imem_addr,       32'h40);
    check_eq("ra_req40",   32'(imem_req),   32'd1);
    tick;
    check_eq("ra_valid40", 32'(valid_id), 32'd1);
    check_eq("ra_pc40",    pc_id,         32'h40);
    tick;
    check_eq("ra_pc44",    pc_id,         32'h44);

    // Reset while dropping a response; a stray ack afterwards is ignored.
    ack_man = 1'b0;
    if_en   = 1'b1;
    do_reset(1'b0, "rd_rst");
    tick;
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    tick;
    redirect = 1'b0;
    check_eq("rd_drop_req",  32'(imem_req), 32'd1);
    check_eq("rd_drop_addr", imem_addr,     32'h0);
    rst = 1'b1;
    tick;
    check_reset_outputs("rd_mid");
    rst     = 1'b0;
    ack_man = 1'b1;
    tick;
    check_eq("rd_req",   32'(imem_req),   32'd1);
    check_eq("rd_addr",  imem_addr,       32'h0);
    check_eq("rd_stray", 32'(valid_id),   32'd0);
    check_eq("rd_busy",  32'(fetch_busy), 32'd1);
    tick;
    check_eq("rd_valid", 32'(valid_id), 32'd1);
    check_eq("rd_pc",    pc_id,         32'h0);
    check_eq("rd_inst",  inst_id,       32'hC0DE_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
